// File: rtl/counter_ctrl_pkg.sv
// Shared constants for the push-button front end: FSM encoding, button
// indices and the state-to-control decode used by the output registers.
package counter_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_PAUSED = 2'b10;

  localparam int MIN_DEBOUNCE_CYCLES = 2;

  localparam int NUM_BTNS  = 4;
  localparam int BTN_START = 0;
  localparam int BTN_PAUSE = 1;
  localparam int BTN_DIR   = 2;
  localparam int BTN_CLEAR = 3;

  typedef struct packed {
    logic enable;
    logic pause;
  } run_ctrl_t;

  function automatic run_ctrl_t state_ctrl(input logic [1:0] st);
    run_ctrl_t c;
    c.enable = (st == ST_RUN) || (st == ST_PAUSED);
    c.pause  = (st == ST_PAUSED);
    return c;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One raw button: 2-flop synchroniser, stable-count debouncer and a
// registered rising-edge detector producing a single-cycle press pulse.
module button_debounce
  import counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W            = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  // Values below the minimum are clamped so the counter width stays valid.
  localparam int CYCLES = (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES) ?
                          MIN_DEBOUNCE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W  = (DB_W > $clog2(CYCLES + 1)) ? DB_W : $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CYCLES);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             level_d_reg;
  logic             press_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      level_reg   <= 1'b0;
      level_d_reg <= 1'b0;
      press_reg   <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
      // Level only moves once the disagreement has persisted for CYCLES counts.
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_DONE) begin
        level_reg <= sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      level_d_reg <= level_reg;
      press_reg   <= level_reg & ~level_d_reg;
    end
  end

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/direction controller for the up/down counter, fed by four
// debounced push buttons; every output is a register.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W            = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_dir,
  input  logic       btn_clear,
  output logic       enable,
  output logic       pause,
  output logic       up_down,
  output logic       clear,
  output logic [1:0] state
);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_press;
  logic [NUM_BTNS-1:0] btn_level_unused;

  assign btn_raw = {btn_clear, btn_dir, btn_pause, btn_start};

  generate
    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DB_W           (DB_W)
      ) u_db (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_raw[gi]),
        .level  (btn_level_unused[gi]),
        .press  (btn_press[gi])
      );
    end
  endgenerate

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic       clear_next;
  logic       enable_reg;
  logic       pause_reg;
  logic       up_down_reg;
  logic       clear_reg;
  run_ctrl_t  ctrl_next;

  // Priority: clear beats start beats pause; losing FSM presses are dropped.
  always_comb begin
    state_next = state_reg;
    clear_next = 1'b0;
    if (btn_press[BTN_CLEAR]) begin
      state_next = ST_IDLE;
      clear_next = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (btn_press[BTN_START]) state_next = ST_RUN;
        end
        ST_RUN: begin
          if (btn_press[BTN_START])      state_next = ST_IDLE;
          else if (btn_press[BTN_PAUSE]) state_next = ST_PAUSED;
        end
        ST_PAUSED: begin
          if (btn_press[BTN_START])      state_next = ST_IDLE;
          else if (btn_press[BTN_PAUSE]) state_next = ST_RUN;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign ctrl_next = state_ctrl(state_next);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      enable_reg  <= 1'b0;
      pause_reg   <= 1'b0;
      up_down_reg <= 1'b1;
      clear_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      enable_reg  <= ctrl_next.enable;
      pause_reg   <= ctrl_next.pause;
      clear_reg   <= clear_next;
      // Direction is independent of the FSM and survives a clear.
      up_down_reg <= up_down_reg ^ btn_press[BTN_DIR];
    end
  end

  assign enable  = enable_reg;
  assign pause   = pause_reg;
  assign up_down = up_down_reg;
  assign clear   = clear_reg;
  assign state   = state_reg;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed, table-driven bench for counter_ctrl with DEBOUNCE_CYCLES=4.
module tb_counter_ctrl;

  logic       clk;
  logic       reset;
  logic       btn_start;
  logic       btn_pause;
  logic       btn_dir;
  logic       btn_clear;
  logic       enable;
  logic       pause;
  logic       up_down;
  logic       clear;
  logic [1:0] state;

  int n_checks;
  int n_fail;
  int clear_seen;

  counter_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_start(btn_start),
    .btn_pause(btn_pause),
    .btn_dir  (btn_dir),
    .btn_clear(btn_clear),
    .enable   (enable),
    .pause    (pause),
    .up_down  (up_down),
    .clear    (clear),
    .state    (state)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (clear === 1'b1) clear_seen <= clear_seen + 1;
  end

  // btn = {clear, dir, pause, start}
  typedef struct {
    logic [3:0] btn;
    int         hold;
    logic       en;
    logic       ps;
    logic       ud;
    logic [1:0] st;
    int         clr;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic en, input logic ps,
                               input logic ud, input logic [1:0] st);
    check({tag, ".enable"},  {31'b0, enable},  {31'b0, en});
    check({tag, ".pause"},   {31'b0, pause},   {31'b0, ps});
    check({tag, ".up_down"}, {31'b0, up_down}, {31'b0, ud});
    check({tag, ".state"},   {30'b0, state},   {30'b0, st});
  endtask

  task automatic drive(input logic [3:0] b);
    btn_start = b[0];
    btn_pause = b[1];
    btn_dir   = b[2];
    btn_clear = b[3];
  endtask

  task automatic press(input logic [3:0] b, input int hold);
    @(negedge clk);
    drive(b);
    repeat (hold) @(negedge clk);
    drive(4'b0000);
    repeat (16) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int clr_base;
    n_checks   = 0;
    n_fail     = 0;
    clear_seen = 0;
    reset      = 1'b0;
    drive(4'b0000);

    vecs[0]  = '{4'b0010, 3, 1'b1, 1'b0, 1'b1, 2'b01, 0}; // pause glitch ignored
    vecs[1]  = '{4'b0010, 8, 1'b1, 1'b1, 1'b1, 2'b10, 0}; // RUN -> PAUSED
    vecs[2]  = '{4'b0010, 8, 1'b1, 1'b0, 1'b1, 2'b01, 0}; // PAUSED -> RUN
    vecs[3]  = '{4'b0100, 8, 1'b1, 1'b0, 1'b0, 2'b01, 0}; // dir in RUN
    vecs[4]  = '{4'b0001, 8, 1'b0, 1'b0, 1'b0, 2'b00, 0}; // RUN -> IDLE
    vecs[5]  = '{4'b0010, 8, 1'b0, 1'b0, 1'b0, 2'b00, 0}; // pause ignored in IDLE
    vecs[6]  = '{4'b0100, 8, 1'b0, 1'b0, 1'b1, 2'b00, 0}; // dir in IDLE
    vecs[7]  = '{4'b0001, 8, 1'b1, 1'b0, 1'b1, 2'b01, 0}; // IDLE -> RUN
    vecs[8]  = '{4'b1001, 8, 1'b0, 1'b0, 1'b1, 2'b00, 1}; // clear beats start
    vecs[9]  = '{4'b0001, 8, 1'b1, 1'b0, 1'b1, 2'b01, 0};
    vecs[10] = '{4'b0010, 8, 1'b1, 1'b1, 1'b1, 2'b10, 0};
    vecs[11] = '{4'b0011, 8, 1'b0, 1'b0, 1'b1, 2'b00, 0}; // start beats pause
    vecs[12] = '{4'b0001, 8, 1'b1, 1'b0, 1'b1, 2'b01, 0};
    vecs[13] = '{4'b1100, 8, 1'b0, 1'b0, 1'b0, 2'b00, 1}; // clear + dir both act
    vecs[14] = '{4'b1000, 8, 1'b0, 1'b0, 1'b0, 2'b00, 1}; // clear in IDLE
    vecs[15] = '{4'b0001, 5, 1'b1, 1'b0, 1'b0, 2'b01, 0}; // shortest accepted press
    vecs[16] = '{4'b0010, 8, 1'b1, 1'b1, 1'b0, 2'b10, 0};

    // Reset and idle
    repeat (2) @(negedge clk);
    check_outputs("in_reset", 1'b0, 1'b0, 1'b1, 2'b00);
    check("in_reset.clear", {31'b0, clear}, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs("after_reset", 1'b0, 1'b0, 1'b1, 2'b00);
    check("after_reset.clear", {31'b0, clear}, 32'd0);

    // Clean start: raw rises before edge k, enable must rise at edge k+8
    @(negedge clk);
    btn_start = 1'b1;
    repeat (8) @(negedge clk);
    check("latency.enable_before_k8", {31'b0, enable}, 32'd0);
    @(negedge clk);
    check("latency.enable_at_k8", {31'b0, enable}, 32'd1);
    check("latency.state_at_k8", {30'b0, state}, 32'd1);
    repeat (1) @(negedge clk);
    btn_start = 1'b0;
    repeat (20) @(negedge clk);
    check_outputs("start_held", 1'b1, 1'b0, 1'b1, 2'b01);

    for (int i = 0; i < 17; i++) begin
      clr_base = clear_seen;
      press(vecs[i].btn, vecs[i].hold);
      check_outputs($sformatf("vec%0d", i), vecs[i].en, vecs[i].ps, vecs[i].ud, vecs[i].st);
      check($sformatf("vec%0d.clear_pulses", i), clear_seen - clr_base, vecs[i].clr);
    end

    // Reset while PAUSED with a dir press half way through debounce
    @(negedge clk);
    btn_dir = 1'b1;
    repeat (4) @(negedge clk);
    check("midreset.state_before", {30'b0, state}, 32'd2);
    check("midreset.up_down_before", {31'b0, up_down}, 32'd0);
    #3;
    reset = 1'b1 ^ 1'b1;
    #1;
    check_outputs("midreset.async", 1'b0, 1'b0, 1'b1, 2'b00);
    check("midreset.clear", {31'b0, clear}, 32'd0);
    btn_dir = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clr_base = clear_seen;
    repeat (20) @(negedge clk);
    check_outputs("midreset.after", 1'b0, 1'b0, 1'b1, 2'b00);
    check("midreset.clear_pulses", clear_seen - clr_base, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Push-button front end for the up/down counter stage. It synchronises, debounces and edge-detects four raw buttons and runs a small run/pause state machine. Its outputs drive the counter's `enable`, `pause`, `up_down` and a clear pulse directly. It sits immediately upstream of the counter, and all of its outputs are registered.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a button level is accepted. Must be ≥ 2. Board builds override it, e.g. 500000.
- `DB_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: width of the debounce counter.

Ports:
- `clk` input, 1 bit: single system clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low. 0 resets the block.
- `btn_start` input, 1 bit: raw, asynchronous, active-high. Toggles between stopped and running.
- `btn_pause` input, 1 bit: raw. Toggles run/pause while the counter is active.
- `btn_dir` input, 1 bit: raw. Toggles count direction.
- `btn_clear` input, 1 bit: raw. Clears the counter and stops it.
- `enable` output, 1 bit: to the counter's `enable`.
- `pause` output, 1 bit: to the counter's `pause`.
- `up_down` output, 1 bit: to the counter's `up_down`. 1 = up.
- `clear` output, 1 bit: one-cycle, active-high pulse to the counter's `reset`.
- `state` output, 2 bits: current FSM state, for LEDs and debug.

## Operation
- Each button passes through: a 2-flop synchroniser, then a debouncer, then a rising-edge detector. The result is a one-cycle `press` pulse.
- Debouncer behaviour:
  - The counter increments while the synchronised level differs from the debounced level.
  - It is cleared whenever the two levels agree.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced level takes the synchronised value and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles produces no press.
- Only the rising edge of the debounced level counts as a press. Holding a button down produces exactly one press.
- FSM states:
  - IDLE: `enable`=0, `pause`=0.
  - RUN: `enable`=1, `pause`=0.
  - PAUSED: `enable`=1, `pause`=1.
- FSM transitions:
  - IDLE: start → RUN. Pause is ignored.
  - RUN: start → IDLE; pause → PAUSED.
  - PAUSED: pause → RUN; start → IDLE.
  - Any state: clear → IDLE, and `clear`=1 for exactly one cycle.
- Direction: a dir press toggles `up_down` in any state. This is independent of the FSM and is not affected by clear.
- Simultaneous presses in the same cycle: clear has priority over start, and start has priority over pause. Lower-priority FSM presses are dropped. A dir press is still honoured in that cycle.
- Reset values (`reset`=0, asynchronous): state=IDLE, `enable`=0, `pause`=0, `up_down`=1, `clear`=0. All synchroniser, debounce and edge registers reset to 0. A reset that arrives mid-debounce discards the partial count.

## Timing
- A raw level that changes before edge k and stays stable appears at the synchroniser output at edge k+2.
- The debounced level updates at edge k+2+`DEBOUNCE_CYCLES`.
- The `press` pulse is registered and is high for the cycle after edge k+3+`DEBOUNCE_CYCLES`.
- Outputs change at edge k+4+`DEBOUNCE_CYCLES`. Total latency is `DEBOUNCE_CYCLES`+4 cycles.
- `clear` is high for exactly one cycle, beginning at the same edge on which `state` becomes IDLE.
- Release of a button also goes through the debouncer. The next press requires a release followed by a new stable press.
- There is no combinational path from any input to any output.

## Structure
- Package `counter_ctrl_pkg`:
  - State encoding: IDLE=2'b00, RUN=2'b01, PAUSED=2'b10. 2'b11 is illegal and recovers to IDLE on the next edge.
  - Minimum-`DEBOUNCE_CYCLES` constant.
- Sub-module `button_debounce`: synchroniser, debounce counter and edge detector. Parameter `DEBOUNCE_CYCLES`; ports `clk`, `reset`, `btn_raw`, `level`, `press`. It is instantiated four times.
- Top level: the FSM, the direction toggle register and the output registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and a 20 ns clock.
- Reset, then idle: hold `reset`=0 for 2 cycles and release → `enable`=0, `pause`=0, `up_down`=1, `clear`=0, `state`=00.
- Clean start: `btn_start` high for 10 cycles starting before edge k → `enable` rises at edge k+8 and `state`=01. It stays high after release, with no second toggle.
- Glitch rejection: `btn_pause` high for 3 cycles while in RUN → no change. Then high for 8 cycles → `pause`=1 and `state`=10. A second 8-cycle press → `pause`=0 and `state`=01.
- Direction: a dir press in RUN gives `up_down`=0. A dir press in IDLE gives `up_down`=1. `enable` is unaffected in both cases.
- Simultaneous: `btn_clear` and `btn_start` pressed together while in RUN → exactly one `clear` pulse, `state`=00, `enable`=0. The start press is dropped.
- Reset mid-operation: assert `reset` in PAUSED while a dir press is halfway through debounce → all outputs take their reset values immediately. After release, no spurious press or `up_down` toggle occurs.
